ps2_mouse_rx: RTL and testbench

PS/2 mouse front end for the peripheral-interface test design; it owns the bidirectional mouse_clk and mouse_data lines. After reset it sends the Enable Data Reporting command (0xF4) and waits for the device's acknowledge (0xFA). It then receives stream-mode 3-byte movement packets and presents each one as decoded movement, button and overflow fields with a one-cycle valid strobe. The tick/game logic downstream consumes these fields instead of touching the PS/2 pins itself.

---
 rtl/ps2_mouse_rx.sv | 258 +++++++++++++++++++++++++
 tb/tb_ps2_mouse_rx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse front end: sends Enable Data Reporting (0xF4), waits for 0xFA,
// then decodes stream-mode 3-byte movement packets into fields plus a valid strobe.
module ps2_mouse_rx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        mouse_clk,
  inout  wire        mouse_data,
  output logic       init_done,
  output logic       packet_valid,
  output logic [2:0] buttons,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       x_ovf,
  output logic       y_ovf,
  output logic       rx_error
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] ACK_BYTE   = 8'hFA;

  typedef enum logic [2:0] {S_INHIBIT, S_REQ, S_TX, S_ACK, S_WAIT_FA, S_STREAM} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic [3:0]    tx_cnt_q, tx_cnt_d;
  logic [3:0]    rx_cnt_q, rx_cnt_d;
  logic [9:0]    rx_shift_q, rx_shift_d;
  logic [1:0]    pkt_idx_q, pkt_idx_d;
  logic [7:0]    b0_q, b0_d, b1_q, b1_d;
  logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d, clk_prev_q, clk_prev_d;
  logic          dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
  logic          init_done_q, init_done_d, packet_valid_q, packet_valid_d;
  logic [2:0]    buttons_q, buttons_d;
  logic [8:0]    dx_q, dx_d, dy_q, dy_d;
  logic          x_ovf_q, x_ovf_d, y_ovf_q, y_ovf_d, rx_error_q, rx_error_d;

  logic        fall, timeout, frame_done, frame_ok, abort;
  logic [10:0] frame;
  logic [7:0]  rx_byte;

  assign fall     = clk_prev_q & ~clk_sync_q;
  assign timeout  = ~fall & (idle_cnt_q == TO_LAST);
  // Current data sample completes the frame on the stop-bit fall.
  assign frame    = {dat_sync_q, rx_shift_q};
  assign rx_byte  = frame[8:1];
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

  always_comb begin
    state_d        = state_q;
    inh_cnt_d      = inh_cnt_q;
    idle_cnt_d     = fall ? '0 : (idle_cnt_q == TO_LAST ? idle_cnt_q : idle_cnt_q + 1'b1);
    tx_cnt_d       = tx_cnt_q;
    rx_cnt_d       = rx_cnt_q;
    rx_shift_d     = rx_shift_q;
    pkt_idx_d      = pkt_idx_q;
    b0_d           = b0_q;
    b1_d           = b1_q;
    clk_oe_d       = clk_oe_q;
    dat_oe_d       = dat_oe_q;
    clk_meta_d     = mouse_clk;
    clk_sync_d     = clk_meta_q;
    clk_prev_d     = clk_sync_q;
    dat_meta_d     = mouse_data;
    dat_sync_d     = dat_meta_q;
    init_done_d    = init_done_q;
    packet_valid_d = 1'b0;
    buttons_d      = buttons_q;
    dx_d           = dx_q;
    dy_d           = dy_q;
    x_ovf_d        = x_ovf_q;
    y_ovf_d        = y_ovf_q;
    rx_error_d     = 1'b0;
    frame_done     = 1'b0;
    abort          = 1'b0;

    if ((state_q == S_WAIT_FA || state_q == S_STREAM) && fall) begin
      rx_shift_d = {dat_sync_q, rx_shift_q[9:1]};
      if (rx_cnt_q == 4'd10) begin
        rx_cnt_d   = '0;
        frame_done = 1'b1;
      end else begin
        rx_cnt_d = rx_cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_INHIBIT: begin
        clk_oe_d   = 1'b1;
        dat_oe_d   = 1'b0;
        idle_cnt_d = '0;
        rx_cnt_d   = '0;
        pkt_idx_d  = '0;
        inh_cnt_d  = inh_cnt_q + 1'b1;
        if (inh_cnt_q == INH_LAST) state_d = S_REQ;
      end
      S_REQ: begin
        clk_oe_d   = 1'b0;
        dat_oe_d   = 1'b1;
        inh_cnt_d  = '0;
        tx_cnt_d   = '0;
        idle_cnt_d = '0;
        state_d    = S_TX;
      end
      S_TX: begin
        if (fall) begin
          tx_cnt_d = tx_cnt_q + 1'b1;
          if (tx_cnt_q < 4'd8)       dat_oe_d = ~CMD_ENABLE[tx_cnt_q[2:0]];
          else if (tx_cnt_q == 4'd8) dat_oe_d = ^CMD_ENABLE; // odd parity bit, inverted for the open-drain enable
          else begin
            dat_oe_d = 1'b0;
            state_d  = S_ACK;
          end
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      S_ACK: begin
        if (fall) begin
          if (!dat_sync_q) state_d = S_WAIT_FA;
          else             abort   = 1'b1;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      S_WAIT_FA: begin
        if (frame_done) begin
          if (frame_ok && rx_byte == ACK_BYTE) begin
            init_done_d = 1'b1;
            state_d     = S_STREAM;
          end else begin
            abort = 1'b1;
          end
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      S_STREAM: begin
        if (frame_done) begin
          if (!frame_ok) begin
            rx_error_d = 1'b1;
            pkt_idx_d  = '0;
          end else begin
            case (pkt_idx_q)
              2'd0: if (rx_byte[3]) begin
                b0_d      = rx_byte;
                pkt_idx_d = 2'd1;
              end
              2'd1: begin
                b1_d      = rx_byte;
                pkt_idx_d = 2'd2;
              end
              default: begin
                buttons_d      = b0_q[2:0];
                dx_d           = {b0_q[4], b1_q};
                dy_d           = {b0_q[5], rx_byte};
                x_ovf_d        = b0_q[6];
                y_ovf_d        = b0_q[7];
                packet_valid_d = 1'b1;
                pkt_idx_d      = '0;
              end
            endcase
          end
        end else if (timeout) begin
          // Stale partial packets are dropped quietly; only a partial frame is an error.
          if (rx_cnt_q != 4'd0) begin
            rx_cnt_d   = '0;
            rx_error_d = 1'b1;
          end
          pkt_idx_d = '0;
        end
      end
      default: state_d = S_INHIBIT;
    endcase

    if (abort) begin
      rx_error_d = 1'b1;
      state_d    = S_INHIBIT;
      inh_cnt_d  = '0;
      clk_oe_d   = 1'b0;
      dat_oe_d   = 1'b0;
      rx_cnt_d   = '0;
      pkt_idx_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_INHIBIT;
      inh_cnt_q      <= '0;
      idle_cnt_q     <= '0;
      tx_cnt_q       <= '0;
      rx_cnt_q       <= '0;
      rx_shift_q     <= '0;
      pkt_idx_q      <= '0;
      b0_q           <= '0;
      b1_q           <= '0;
      clk_oe_q       <= 1'b0;
      dat_oe_q       <= 1'b0;
      clk_meta_q     <= 1'b1;
      clk_sync_q     <= 1'b1;
      clk_prev_q     <= 1'b1;
      dat_meta_q     <= 1'b1;
      dat_sync_q     <= 1'b1;
      init_done_q    <= 1'b0;
      packet_valid_q <= 1'b0;
      buttons_q      <= '0;
      dx_q           <= '0;
      dy_q           <= '0;
      x_ovf_q        <= 1'b0;
      y_ovf_q        <= 1'b0;
      rx_error_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      inh_cnt_q      <= inh_cnt_d;
      idle_cnt_q     <= idle_cnt_d;
      tx_cnt_q       <= tx_cnt_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_shift_q     <= rx_shift_d;
      pkt_idx_q      <= pkt_idx_d;
      b0_q           <= b0_d;
      b1_q           <= b1_d;
      clk_oe_q       <= clk_oe_d;
      dat_oe_q       <= dat_oe_d;
      clk_meta_q     <= clk_meta_d;
      clk_sync_q     <= clk_sync_d;
      clk_prev_q     <= clk_prev_d;
      dat_meta_q     <= dat_meta_d;
      dat_sync_q     <= dat_sync_d;
      init_done_q    <= init_done_d;
      packet_valid_q <= packet_valid_d;
      buttons_q      <= buttons_d;
      dx_q           <= dx_d;
      dy_q           <= dy_d;
      x_ovf_q        <= x_ovf_d;
      y_ovf_q        <= y_ovf_d;
      rx_error_q     <= rx_error_d;
    end
  end

  assign mouse_clk    = clk_oe_q ? 1'b0 : 1'bz;
  assign mouse_data   = dat_oe_q ? 1'b0 : 1'bz;
  assign init_done    = init_done_q;
  assign packet_valid = packet_valid_q;
  assign buttons      = buttons_q;
  assign dx           = dx_q;
  assign dy           = dy_q;
  assign x_ovf        = x_ovf_q;
  assign y_ovf        = y_ovf_q;
  assign rx_error     = rx_error_q;
endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Bench for ps2_mouse_rx: open-drain PS/2 device model, packet-level reference model,
// directed scenarios followed by a randomized byte stream.
module tb_ps2_mouse_rx;
  localparam int INH  = 500;
  localparam int TO   = 2000;
  localparam int HALF = 20;
  localparam int GAP  = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk_oe = 1'b0;
  logic dev_dat_oe = 1'b0;
  wire  mouse_clk, mouse_data;
  logic init_done, packet_valid, x_ovf, y_ovf, rx_error;
  logic [2:0] buttons;
  logic [8:0] dx, dy;

  pullup (mouse_clk);
  pullup (mouse_data);
  assign mouse_clk  = dev_clk_oe ? 1'b0 : 1'bz;
  assign mouse_data = dev_dat_oe ? 1'b0 : 1'bz;

  ps2_mouse_rx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .mouse_clk(mouse_clk), .mouse_data(mouse_data),
    .init_done(init_done), .packet_valid(packet_valid), .buttons(buttons),
    .dx(dx), .dy(dy), .x_ovf(x_ovf), .y_ovf(y_ovf), .rx_error(rx_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int btn;
    int dx;
    int dy;
    int xo;
    int yo;
  } pkt_t;

  pkt_t got_q[$];
  pkt_t exp_q[$];
  int   err_seen = 0;
  int   got_base = 0, exp_base = 0, err_base = 0, err_exp = 0;
  int   n_chk = 0, n_err = 0;
  int   m_idx = 0, m_b0 = 0, m_b1 = 0;

  always @(negedge clk) begin : mon
    pkt_t p;
    if (packet_valid) begin
      p.btn = int'(buttons);
      p.dx  = int'($signed(dx));
      p.dy  = int'($signed(dy));
      p.xo  = int'(x_ovf);
      p.yo  = int'(y_ovf);
      got_q.push_back(p);
    end
    if (rx_error) err_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Packet-level reference: index 0..2, alignment on byte0 bit3, bad byte restarts.
  task automatic m_byte(input logic [7:0] b, input bit good);
    pkt_t p;
    int   bi;
    bi = int'(b);
    if (!good) begin
      err_exp++;
      m_idx = 0;
    end else if (m_idx == 0) begin
      if (b[3]) begin
        m_b0  = bi;
        m_idx = 1;
      end
    end else if (m_idx == 1) begin
      m_b1  = bi;
      m_idx = 2;
    end else begin
      p.btn = m_b0 % 8;
      p.dx  = ((m_b0 / 16) % 2 == 1) ? m_b1 - 256 : m_b1;
      p.dy  = ((m_b0 / 32) % 2 == 1) ? bi - 256 : bi;
      p.xo  = (m_b0 / 64) % 2;
      p.yo  = m_b0 / 128;
      exp_q.push_back(p);
      m_idx = 0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      dev_dat_oe = ~f[k];
      repeat (HALF / 2) @(negedge clk);
      dev_clk_oe = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_oe = 1'b0;
      repeat (HALF / 2) @(negedge clk);
    end
    dev_dat_oe = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit bad);
    send_frame(b, bad, 11);
    m_byte(b, !bad);
  endtask

  task automatic idle_long();
    repeat (TO + 300) @(negedge clk);
    m_idx = 0;
  endtask

  task automatic check_pkts(input string tag);
    int ng, ne, n;
    repeat (20) @(negedge clk);
    ng = got_q.size() - got_base;
    ne = exp_q.size() - exp_base;
    chk({tag, ".npkt"}, ng, ne);
    n = (ng < ne) ? ng : ne;
    for (int i = 0; i < n; i++) begin
      chk({tag, ".btn"}, got_q[got_base+i].btn, exp_q[exp_base+i].btn);
      chk({tag, ".dx"},  got_q[got_base+i].dx,  exp_q[exp_base+i].dx);
      chk({tag, ".dy"},  got_q[got_base+i].dy,  exp_q[exp_base+i].dy);
      chk({tag, ".xo"},  got_q[got_base+i].xo,  exp_q[exp_base+i].xo);
      chk({tag, ".yo"},  got_q[got_base+i].yo,  exp_q[exp_base+i].yo);
    end
    got_base = got_q.size();
    exp_base = exp_q.size();
    chk({tag, ".nerr"}, err_seen - err_base, err_exp);
    err_base = err_seen;
    err_exp  = 0;
  endtask

  // Host request, 0xF4 shift-out, acknowledge, then 0xFA back to the host.
  task automatic do_init(input string tag);
    logic [10:0] bits, fexp;
    logic [7:0]  cmd;
    int          n;
    bit          ok;
    cmd  = 8'hF4;
    fexp = {1'b1, ~^cmd, cmd, 1'b0};
    ok   = 1'b0;
    n    = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (mouse_clk === 1'b0) ok = 1'b1;
    end
    chk({tag, ".inh_start"}, int'(ok), 1);
    while (mouse_clk === 1'b0 && n < INH + 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, ".inh_len"}, n, INH);
    chk({tag, ".req_data"}, int'(mouse_data === 1'b0), 1);
    for (int k = 0; k < 11; k++) begin
      repeat (HALF) @(negedge clk);
      bits[k] = (mouse_data !== 1'b0);
      if (k == 10) begin
        dev_dat_oe = 1'b1;
        repeat (HALF / 2) @(negedge clk);
      end
      dev_clk_oe = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_oe = 1'b0;
    end
    dev_dat_oe = 1'b0;
    chk({tag, ".tx_frame"}, int'(bits), int'(fexp));
    repeat (100) @(negedge clk);
    chk({tag, ".done_early"}, int'(init_done), 0);
    send_frame(8'hFA, 1'b0, 11);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (init_done === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    chk({tag, ".init_done"}, int'(ok), 1);
    chk({tag, ".clk_rel"}, int'(mouse_clk === 1'b1), 1);
    chk({tag, ".dat_rel"}, int'(mouse_data === 1'b1), 1);
  endtask

  initial begin
    logic [7:0] b;
    bit         bad;
    repeat (4) @(negedge clk);
    chk("rst.init_done", int'(init_done), 0);
    chk("rst.valid", int'(packet_valid), 0);
    chk("rst.err", int'(rx_error), 0);
    chk("rst.clk_rel", int'(mouse_clk === 1'b1), 1);
    rst = 1'b0;

    do_init("init1");
    check_pkts("init1");

    send(8'h28, 1'b0); send(8'h10, 1'b0); send(8'hF0, 1'b0);
    check_pkts("basic");

    send(8'h09, 1'b0); send(8'h00, 1'b1); send(8'h00, 1'b0);
    send(8'h09, 1'b0); send(8'hFF, 1'b0); send(8'h01, 1'b0);
    check_pkts("parity");

    send(8'h00, 1'b0);
    send(8'h28, 1'b0); send(8'h10, 1'b0); send(8'hF0, 1'b0);
    check_pkts("align");

    send(8'h28, 1'b0); send(8'h10, 1'b0);
    idle_long();
    send(8'h08, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b0);
    check_pkts("stale");

    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom_range(0, 255));
      if (m_idx == 0 && $urandom_range(0, 3) != 0) b[3] = 1'b1;
      bad = ($urandom_range(0, 9) == 0);
      send(b, bad);
      if ($urandom_range(0, 24) == 0) idle_long();
    end
    send(8'hC8, 1'b0); send(8'h80, 1'b0); send(8'h7F, 1'b0);
    check_pkts("rand");

    send(8'h28, 1'b0);
    send_frame(8'h10, 1'b0, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst.init_done", int'(init_done), 0);
    chk("mrst.dx", int'(dx), 0);
    chk("mrst.dy", int'(dy), 0);
    chk("mrst.btn", int'(buttons), 0);
    chk("mrst.err", int'(rx_error), 0);
    chk("mrst.clk_rel", int'(mouse_clk === 1'b1), 1);
    chk("mrst.dat_rel", int'(mouse_data === 1'b1), 1);
    m_idx    = 0;
    err_base = err_seen;
    err_exp  = 0;
    got_base = got_q.size();
    exp_base = exp_q.size();

    do_init("init2");
    send(8'h3A, 1'b0); send(8'h05, 1'b0); send(8'hFB, 1'b0);
    check_pkts("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
